fb_write_scheduler: RTL and testbench
=====================================

Name: fb_write_scheduler

Overview:
- Sits between the core's memory-stage framebuffer write outputs (fb_wr_en/x/y/value) and the single framebuffer write port.
- Buffers core pixel writes in a small FIFO and adds a hardware fill ("clear screen") engine.
- Arbitrates both sources onto one ready-qualified write port, preserving program order.
- Raises a stall to the hazard unit before the FIFO can overflow.

Parameters:
- RESOLUTION_X, 400, pixels per row
- RESOLUTION_Y, 300, rows
- PALETTE_LENGTH, 256, palette entries; pixel value width = $clog2(PALETTE_LENGTH)
- FIFO_DEPTH, 8, core-write FIFO entries; power of 2, minimum 4
- STALL_MARGIN, 3, free-entry headroom covering writes already in flight in the pipeline

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- fb_wr_en  in  1  core pixel write strobe, one pixel per cycle
- fb_wr_pxl_x  in  $clog2(RESOLUTION_X)  core write x
- fb_wr_pxl_y  in  $clog2(RESOLUTION_Y)  core write y
- fb_wr_pxl_value  in  $clog2(PALETTE_LENGTH)  core write palette index
- fb_stall  out  1  to hazard unit; stall fetch/decode
- fill_start  in  1  one-cycle fill command
- fill_value  in  $clog2(PALETTE_LENGTH)  fill colour, sampled with fill_start
- fill_busy  out  1  fill pending or in progress
- fbm_wr_en  out  1  framebuffer port write valid
- fbm_x  out  $clog2(RESOLUTION_X)  port x
- fbm_y  out  $clog2(RESOLUTION_Y)  port y
- fbm_value  out  $clog2(PALETTE_LENGTH)  port value
- fbm_ready  in  1  port accepts when fbm_wr_en && fbm_ready
- overflow  out  1  sticky: a core write arrived while the FIFO was full with no pop

Behaviour:
- Reset state:
  - All outputs 0.
  - FIFO empty.
  - State IDLE.
  - Fill counters 0.
  - Reset mid-fill aborts the fill and discards queued writes.
- FIFO push and pop:
  - Push on fb_wr_en.
  - Pop on an accepted port beat sourced from the FIFO.
  - Push and pop in the same cycle while full: allowed, count unchanged.
  - Push while full with no pop: write dropped, overflow set until reset.
- fb_stall:
  - Registered: next = (count_next >= FIFO_DEPTH - STALL_MARGIN).
  - Deasserts one cycle after count drops below the threshold.
- State machine:
  - IDLE: the FIFO head drives the port (fbm_wr_en = !empty). fill_start latches fill_value, sets fill_busy the next cycle, and moves to DRAIN.
  - DRAIN: the FIFO head drives the port, but only entries queued before fill_start. Track this with a drain counter loaded with the count at fill_start. When the drain counter reaches 0, move to FILL.
  - FILL: the fill pixel at (fx, fy, fill_value) drives the port. Core writes keep queuing in the FIFO and are not issued, so they land after the fill.
    - On each accept, fx increments; at RESOLUTION_X-1, fx wraps to 0 and fy increments.
    - On accept of (RESOLUTION_X-1, RESOLUTION_Y-1): go to IDLE, clear fill_busy the next cycle, reset counters.
- fill_start while fill_busy: ignored.
- Port outputs are combinational from the FIFO head or fill counters.
  - Values hold stable while fbm_wr_en && !fbm_ready.
- Latency: a core write arriving into an empty FIFO in IDLE appears on the port the next cycle (FIFO is registered).
- Full fill: RESOLUTION_X*RESOLUTION_Y accepted beats, 120000 at defaults.

Optional Feature:
- Macro: FB_BOUNDS_CHECK_EN.
- Defined:
  - Core writes with x >= RESOLUTION_X or y >= RESOLUTION_Y are discarded before the FIFO. They do not push and do not set overflow.
  - Adds output oob_count (16 bits, saturating, reset 0) counting discarded writes.
- Undefined:
  - All writes are queued unchecked.
  - oob_count port is absent.

Decomposition:
- Package fb_sched_pkg:
  - fb_sched_state_t enum {IDLE, DRAIN, FILL}
  - fb_pixel_t packed struct {x, y, value}, sized by package localparams matching the defaults
- Sub-module fb_fifo: synchronous FIFO of fb_pixel_t with push, pop, full, empty and count. Instantiated once.

Test Plan:
- Single write, port always ready: core writes (10,20,0x05) with fbm_ready=1 -> fbm_wr_en high the next cycle with (10,20,0x05), FIFO empty after.
- Stall threshold: fbm_ready=0, push 5 writes -> fb_stall rises the cycle after the 5th push (count=5 >= 8-3). Set fbm_ready=1 -> fb_stall falls once count<5.
- Overflow: fbm_ready=0, push 9 writes -> 9th dropped, overflow=1, FIFO holds the first 8 in order.
- Ordering across a fill: 2 queued writes, fill_start with value 0x00, then 1 more core write -> port sequence is the 2 writes, then 120000 fill beats ending (399,299), then the 3rd write. fill_busy clears after the last fill beat.
- Backpressure in FILL: toggle fbm_ready 1010… -> fx/fy advance only on accepted beats, no pixel skipped or repeated, row wrap at x=399.
- Reset mid-fill: assert reset at fill pixel (5,3) -> next cycle fbm_wr_en=0, fill_busy=0, FIFO empty. With FB_BOUNDS_CHECK_EN: write (400,0) -> not issued, oob_count=1.

Source files
------------

// File: rtl/fb_sched_pkg.sv
// fb_write_scheduler shared types: scheduler states and the pixel bundle
// that travels through the core-write FIFO.
package fb_sched_pkg;

  localparam int FB_RES_X   = 400;
  localparam int FB_RES_Y   = 300;
  localparam int FB_PAL_LEN = 256;

  localparam int FB_XW = $clog2(FB_RES_X);
  localparam int FB_YW = $clog2(FB_RES_Y);
  localparam int FB_VW = $clog2(FB_PAL_LEN);

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    FILL
  } fb_sched_state_t;

  typedef struct packed {
    logic [FB_XW-1:0] x;
    logic [FB_YW-1:0] y;
    logic [FB_VW-1:0] value;
  } fb_pixel_t;

endpackage

// File: rtl/fb_fifo.sv
// fb_fifo: registered synchronous FIFO of fb_pixel_t.
// A push into a full FIFO is only taken when a pop happens the same cycle.
module fb_fifo
  import fb_sched_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  fb_pixel_t              data_i,
  input  logic                   pop_i,
  output fb_pixel_t              head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fb_pixel_t         mem_q [DEPTH];
  logic [AW-1:0]     wr_q;
  logic [AW-1:0]     rd_q;
  logic [CW-1:0]     cnt_q;
  logic              do_push;
  logic              do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Pointers and occupancy
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage, no reset needed
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/fb_write_scheduler.sv
// fb_write_scheduler: queues core pixel writes and a fill engine onto one
// framebuffer port in program order. Option: FB_BOUNDS_CHECK_EN.
module fb_write_scheduler
  import fb_sched_pkg::*;
#(
  parameter int RESOLUTION_X   = FB_RES_X,
  parameter int RESOLUTION_Y   = FB_RES_Y,
  parameter int PALETTE_LENGTH = FB_PAL_LEN,
  parameter int FIFO_DEPTH     = 8,
  parameter int STALL_MARGIN   = 3
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              fb_wr_en,
  input  logic [$clog2(RESOLUTION_X)-1:0]   fb_wr_pxl_x,
  input  logic [$clog2(RESOLUTION_Y)-1:0]   fb_wr_pxl_y,
  input  logic [$clog2(PALETTE_LENGTH)-1:0] fb_wr_pxl_value,
  output logic                              fb_stall,
  input  logic                              fill_start,
  input  logic [$clog2(PALETTE_LENGTH)-1:0] fill_value,
  output logic                              fill_busy,
  output logic                              fbm_wr_en,
  output logic [$clog2(RESOLUTION_X)-1:0]   fbm_x,
  output logic [$clog2(RESOLUTION_Y)-1:0]   fbm_y,
  output logic [$clog2(PALETTE_LENGTH)-1:0] fbm_value,
  input  logic                              fbm_ready,
  output logic                              overflow
`ifdef FB_BOUNDS_CHECK_EN
  ,
  output logic [15:0]                       oob_count
`endif
);

  localparam int XW = $clog2(RESOLUTION_X);
  localparam int YW = $clog2(RESOLUTION_Y);
  localparam int VW = $clog2(PALETTE_LENGTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fb_sched_state_t state_q, state_d;
  logic [XW-1:0]   fx_q, fx_d;
  logic [YW-1:0]   fy_q, fy_d;
  logic [VW-1:0]   fval_q, fval_d;
  logic [CW-1:0]   drain_q, drain_d;
  logic            stall_q;
  logic            ovf_q;

  fb_pixel_t       wr_pix;
  fb_pixel_t       head;
  logic            full;
  logic            empty;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_next;
  logic            in_range;
  logic            push_req;
  logic            push_ok;
  logic            accept;
  logic            pop_fire;

`ifdef FB_BOUNDS_CHECK_EN
  assign in_range = (int'(fb_wr_pxl_x) < RESOLUTION_X) &&
                    (int'(fb_wr_pxl_y) < RESOLUTION_Y);
`else
  assign in_range = 1'b1;
`endif

  assign wr_pix = '{
    x:     FB_XW'(fb_wr_pxl_x),
    y:     FB_YW'(fb_wr_pxl_y),
    value: FB_VW'(fb_wr_pxl_value)
  };

  assign push_req   = fb_wr_en && in_range;
  assign accept     = fbm_wr_en && fbm_ready;
  assign pop_fire   = accept && (state_q != FILL);
  assign push_ok    = push_req && (!full || pop_fire);
  assign count_next = count + CW'(push_ok) - CW'(pop_fire);

  fb_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk),
    .rst_i  (reset),
    .push_i (push_req),
    .data_i (wr_pix),
    .pop_i  (pop_fire),
    .head_o (head),
    .full_o (full),
    .empty_o(empty),
    .count_o(count)
  );

  // Scheduler state and fill counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      fx_q    <= '0;
      fy_q    <= '0;
      fval_q  <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      fx_q    <= fx_d;
      fy_q    <= fy_d;
      fval_q  <= fval_d;
      drain_q <= drain_d;
    end
  end

  // Next state: drain pre-fill entries, then walk the frame
  always_comb begin
    state_d = state_q;
    fx_d    = fx_q;
    fy_d    = fy_q;
    fval_d  = fval_q;
    drain_d = drain_q;
    unique case (state_q)
      IDLE: begin
        if (fill_start) begin
          fval_d  = fill_value;
          drain_d = count - CW'(pop_fire);
          state_d = (drain_d == '0) ? FILL : DRAIN;
        end
      end
      DRAIN: begin
        if (pop_fire) begin
          drain_d = drain_q - 1'b1;
          if (drain_d == '0) state_d = FILL;
        end
      end
      FILL: begin
        if (accept) begin
          if (fx_q == XW'(RESOLUTION_X - 1)) begin
            fx_d = '0;
            if (fy_q == YW'(RESOLUTION_Y - 1)) begin
              fy_d    = '0;
              state_d = IDLE;
            end else begin
              fy_d = fy_q + 1'b1;
            end
          end else begin
            fx_d = fx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Port mux: FIFO head or fill pixel, zero when not valid
  always_comb begin
    fbm_wr_en = 1'b0;
    fbm_x     = '0;
    fbm_y     = '0;
    fbm_value = '0;
    fill_busy = (state_q != IDLE);
    unique case (state_q)
      IDLE, DRAIN: begin
        fbm_wr_en = !empty && (state_q == IDLE || drain_q != '0);
        if (fbm_wr_en) begin
          fbm_x     = XW'(head.x);
          fbm_y     = YW'(head.y);
          fbm_value = VW'(head.value);
        end
      end
      FILL: begin
        fbm_wr_en = 1'b1;
        fbm_x     = fx_q;
        fbm_y     = fy_q;
        fbm_value = fval_q;
      end
      default: fbm_wr_en = 1'b0;
    endcase
  end

  // Early stall and sticky overflow flag
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      stall_q <= (count_next >= CW'(FIFO_DEPTH - STALL_MARGIN));
      if (push_req && full && !pop_fire) ovf_q <= 1'b1;
    end
  end

  assign fb_stall = stall_q;
  assign overflow = ovf_q;

`ifdef FB_BOUNDS_CHECK_EN
  logic [15:0] oob_q;

  // Saturating count of discarded out-of-range writes
  always_ff @(posedge clk) begin
    if (reset) begin
      oob_q <= '0;
    end else if (fb_wr_en && !in_range && oob_q != 16'hFFFF) begin
      oob_q <= oob_q + 16'd1;
    end
  end

  assign oob_count = oob_q;
`endif

endmodule

// File: tb/tb_fb_write_scheduler.sv
// tb_fb_write_scheduler: randomized bench with a queue-based reference
// model; small frame so full fills stay short.
module tb_fb_write_scheduler;

  localparam int RX = 20;
  localparam int RY = 24;
  localparam int DEPTH = 8;
  localparam int MARGIN = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       fb_wr_en = 1'b0;
  logic [4:0] fb_wr_pxl_x = '0;
  logic [4:0] fb_wr_pxl_y = '0;
  logic [7:0] fb_wr_pxl_value = '0;
  logic       fb_stall;
  logic       fill_start = 1'b0;
  logic [7:0] fill_value = '0;
  logic       fill_busy;
  logic       fbm_wr_en;
  logic [4:0] fbm_x;
  logic [4:0] fbm_y;
  logic [7:0] fbm_value;
  logic       fbm_ready = 1'b0;
  logic       overflow;
`ifdef FB_BOUNDS_CHECK_EN
  logic [15:0] oob_count;
`endif

  fb_write_scheduler #(
    .RESOLUTION_X  (RX),
    .RESOLUTION_Y  (RY),
    .PALETTE_LENGTH(256),
    .FIFO_DEPTH    (DEPTH),
    .STALL_MARGIN  (MARGIN)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .fb_wr_en       (fb_wr_en),
    .fb_wr_pxl_x    (fb_wr_pxl_x),
    .fb_wr_pxl_y    (fb_wr_pxl_y),
    .fb_wr_pxl_value(fb_wr_pxl_value),
    .fb_stall       (fb_stall),
    .fill_start     (fill_start),
    .fill_value     (fill_value),
    .fill_busy      (fill_busy),
    .fbm_wr_en      (fbm_wr_en),
    .fbm_x          (fbm_x),
    .fbm_y          (fbm_y),
    .fbm_value      (fbm_value),
    .fbm_ready      (fbm_ready),
    .overflow       (overflow)
`ifdef FB_BOUNDS_CHECK_EN
    ,
    .oob_count      (oob_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int v;
  } px_t;

  // Reference model: queued writes, pending fill and its cut point
  px_t mq[$];
  bit  fact;
  int  cut;
  int  fpos;
  int  fval;
  bit  m_ovf;
  int  m_oob;
  int  total = 0;
  int  bad = 0;

  function automatic bit exp_valid();
    return fact || (mq.size() > 0);
  endfunction

  function automatic px_t exp_px();
    px_t p;
    if (fact && cut == 0) begin
      p.x = fpos % RX;
      p.y = fpos / RX;
      p.v = fval;
    end else begin
      p = mq[0];
    end
    return p;
  endfunction

  function automatic bit exp_stall();
    return mq.size() >= DEPTH - MARGIN;
  endfunction

  task automatic drive(input bit en, input int x, input int y,
                       input int v, input bit fs, input int fv,
                       input bit rdy);
    fb_wr_en        = en;
    fb_wr_pxl_x     = 5'(x);
    fb_wr_pxl_y     = 5'(y);
    fb_wr_pxl_value = 8'(v);
    fill_start      = fs;
    fill_value      = 8'(fv);
    fbm_ready       = rdy;
  endtask

  // Advance model by one clock using the driven inputs, then clock DUT
  task automatic tick();
    bit acc;
    bit pre;
    bit inr;
    if (reset) begin
      mq.delete();
      fact  = 0;
      cut   = 0;
      fpos  = 0;
      m_ovf = 0;
      m_oob = 0;
    end else begin
      pre = fact;
      acc = exp_valid() && fbm_ready;
      if (acc) begin
        if (fact && cut == 0) begin
          fpos++;
          if (fpos == RX * RY) begin
            fact = 0;
            fpos = 0;
          end
        end else begin
          void'(mq.pop_front());
          if (fact) cut--;
        end
      end
      if (fill_start && !pre) begin
        fact = 1;
        cut  = mq.size();
        fval = int'(fill_value);
      end
      if (fb_wr_en) begin
        inr = 1;
`ifdef FB_BOUNDS_CHECK_EN
        inr = (int'(fb_wr_pxl_x) < RX) && (int'(fb_wr_pxl_y) < RY);
`endif
        if (!inr) begin
          if (m_oob < 65535) m_oob++;
        end else if (mq.size() < DEPTH) begin
          mq.push_back('{int'(fb_wr_pxl_x), int'(fb_wr_pxl_y),
                         int'(fb_wr_pxl_value)});
        end else begin
          m_ovf = 1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    total++;
    if ({fbm_wr_en, fb_stall, fill_busy, overflow} !== 4'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b exp=0000",
               {fbm_wr_en, fb_stall, fill_busy, overflow});
    end
    total++;
    if ({fbm_x, fbm_y, fbm_value} !== 18'h0) begin
      bad++;
      $display("FAIL reset_port got=%0h exp=0", {fbm_x, fbm_y, fbm_value});
    end
`ifdef FB_BOUNDS_CHECK_EN
    total++;
    if (oob_count !== 16'd0) begin
      bad++;
      $display("FAIL reset_oob got=%0d exp=0", oob_count);
    end
`endif
  endtask

  task automatic test_single();
    do_reset();
    drive(1, 10, 20, 5, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 1);
    total++;
    if (fbm_wr_en !== 1'b1 || fbm_x !== 5'd10 || fbm_y !== 5'd20 ||
        fbm_value !== 8'h05) begin
      bad++;
      $display("FAIL single_beat got=%b/%0d/%0d/%0h exp=1/10/20/5",
               fbm_wr_en, fbm_x, fbm_y, fbm_value);
    end
    tick();
    total++;
    if (fbm_wr_en !== 1'b0) begin
      bad++;
      $display("FAIL single_empty got=%b exp=0", fbm_wr_en);
    end
  endtask

  task automatic test_stall();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1, i, i, i + 1, 0, 0, 0);
      tick();
      total++;
      if (fb_stall !== exp_stall()) begin
        bad++;
        $display("FAIL stall_fill i=%0d got=%b exp=%b",
                 i, fb_stall, exp_stall());
      end
    end
    total++;
    if (fb_stall !== 1'b1) begin
      bad++;
      $display("FAIL stall_at5 got=%b exp=1", fb_stall);
    end
    drive(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) begin
      tick();
      total++;
      if (fb_stall !== exp_stall()) begin
        bad++;
        $display("FAIL stall_drain i=%0d got=%b exp=%b",
                 i, fb_stall, exp_stall());
      end
    end
  endtask

  task automatic test_overflow();
    px_t e;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive(1, i, 2 * i, 8'h30 + i, 0, 0, 0);
      tick();
    end
    total++;
    if (overflow !== m_ovf || overflow !== 1'b1) begin
      bad++;
      $display("FAIL overflow_flag got=%b exp=%b", overflow, m_ovf);
    end
    drive(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 9; i++) begin
      total++;
      if (fbm_wr_en !== exp_valid()) begin
        bad++;
        $display("FAIL ovf_valid i=%0d got=%b exp=%b",
                 i, fbm_wr_en, exp_valid());
      end else if (fbm_wr_en) begin
        e = exp_px();
        total++;
        if ({fbm_x, fbm_y, fbm_value} !== {5'(e.x), 5'(e.y), 8'(e.v)}) begin
          bad++;
          $display("FAIL ovf_order i=%0d got=%0d,%0d,%0h exp=%0d,%0d,%0h",
                   i, fbm_x, fbm_y, fbm_value, e.x, e.y, e.v);
        end
      end
      tick();
    end
  endtask

  task automatic test_fill_order();
    px_t e;
    int  n;
    do_reset();
    drive(1, 1, 2, 8'hA1, 0, 0, 0);
    tick();
    drive(1, 3, 4, 8'hA2, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 1, 0, 0);
    tick();
    drive(1, 5, 6, 8'hA3, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 1);
    n = 0;
    while (exp_valid() && n < RX * RY + 50) begin
      total++;
      if (fbm_wr_en !== 1'b1 || fill_busy !== fact) begin
        bad++;
        $display("FAIL order_ctl n=%0d got=%b%b exp=1%b",
                 n, fbm_wr_en, fill_busy, fact);
      end
      e = exp_px();
      total++;
      if ({fbm_x, fbm_y, fbm_value} !== {5'(e.x), 5'(e.y), 8'(e.v)}) begin
        bad++;
        $display("FAIL order_beat n=%0d got=%0d,%0d,%0h exp=%0d,%0d,%0h",
                 n, fbm_x, fbm_y, fbm_value, e.x, e.y, e.v);
      end
      tick();
      n++;
    end
    total++;
    if (n != RX * RY + 3 || fbm_wr_en !== 1'b0 || fill_busy !== 1'b0) begin
      bad++;
      $display("FAIL order_end beats=%0d en=%b busy=%b exp=%0d/0/0",
               n, fbm_wr_en, fill_busy, RX * RY + 3);
    end
  endtask

  task automatic test_backpressure();
    px_t e;
    int  c;
    do_reset();
    drive(0, 0, 0, 0, 1, $urandom_range(0, 255), 0);
    tick();
    c = 0;
    while (exp_valid() && c < 4 * RX * RY) begin
      drive($urandom_range(0, 7) == 0, $urandom_range(0, RX - 1),
            $urandom_range(0, RY - 1), $urandom_range(0, 255),
            0, 0, (c % 2) == 0);
      total++;
      if (fbm_wr_en !== 1'b1 || fill_busy !== fact) begin
        bad++;
        $display("FAIL bp_ctl c=%0d got=%b%b exp=1%b",
                 c, fbm_wr_en, fill_busy, fact);
      end
      e = exp_px();
      total++;
      if ({fbm_x, fbm_y, fbm_value} !== {5'(e.x), 5'(e.y), 8'(e.v)}) begin
        bad++;
        $display("FAIL bp_beat c=%0d got=%0d,%0d,%0h exp=%0d,%0d,%0h",
                 c, fbm_x, fbm_y, fbm_value, e.x, e.y, e.v);
      end
      tick();
      c++;
    end
    total++;
    if (exp_valid()) begin
      bad++;
      $display("FAIL bp_timeout got=%0d cycles exp=<%0d", c, 4 * RX * RY);
    end
  endtask

  task automatic test_random();
    px_t e;
    int  x;
    int  y;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      x = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 31)
                                      : $urandom_range(0, RX - 1);
      y = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 31)
                                      : $urandom_range(0, RY - 1);
      drive($urandom_range(0, 1), x, y, $urandom_range(0, 255),
            $urandom_range(0, 199) == 0, $urandom_range(0, 255),
            $urandom_range(0, 3) != 0);
      total++;
      if (fbm_wr_en !== exp_valid() || fill_busy !== fact ||
          fb_stall !== exp_stall() || overflow !== m_ovf) begin
        bad++;
        $display("FAIL rnd_ctl c=%0d got=%b%b%b%b exp=%b%b%b%b", c,
                 fbm_wr_en, fill_busy, fb_stall, overflow,
                 exp_valid(), fact, exp_stall(), m_ovf);
      end else if (fbm_wr_en) begin
        e = exp_px();
        total++;
        if ({fbm_x, fbm_y, fbm_value} !== {5'(e.x), 5'(e.y), 8'(e.v)}) begin
          bad++;
          $display("FAIL rnd_beat c=%0d got=%0d,%0d,%0h exp=%0d,%0d,%0h",
                   c, fbm_x, fbm_y, fbm_value, e.x, e.y, e.v);
        end
      end
`ifdef FB_BOUNDS_CHECK_EN
      total++;
      if (oob_count !== 16'(m_oob)) begin
        bad++;
        $display("FAIL rnd_oob c=%0d got=%0d exp=%0d", c, oob_count, m_oob);
      end
`endif
      tick();
    end
  endtask

  task automatic test_reset_midfill();
    int c;
    do_reset();
    drive(0, 0, 0, 0, 1, 8'h77, 1);
    tick();
    c = 0;
    while (!(fact && fpos == 3 * RX + 5) && c < 200) begin
      drive((c % 10) == 0, 2, 2, c, 0, 0, 1);
      tick();
      c++;
    end
    drive(0, 0, 0, 0, 0, 0, 1);
    total++;
    if (fbm_x !== 5'd5 || fbm_y !== 5'd3 || fill_busy !== 1'b1 ||
        mq.size() == 0) begin
      bad++;
      $display("FAIL midfill_pos got=%0d,%0d busy=%b q=%0d exp=5,3 busy=1",
               fbm_x, fbm_y, fill_busy, mq.size());
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      total++;
      if ({fbm_wr_en, fill_busy, fb_stall} !== 3'b000) begin
        bad++;
        $display("FAIL midfill_reset i=%0d got=%b exp=000",
                 i, {fbm_wr_en, fill_busy, fb_stall});
      end
      tick();
    end
  endtask

`ifdef FB_BOUNDS_CHECK_EN
  task automatic test_oob();
    do_reset();
    drive(1, RX, 0, 8'h12, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 1);
    total++;
    if (fbm_wr_en !== 1'b0 || oob_count !== 16'd1 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL oob_drop got=%b/%0d/%b exp=0/1/0",
               fbm_wr_en, oob_count, overflow);
    end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_stall();
    test_overflow();
    test_fill_order();
    test_backpressure();
    test_reset_midfill();
`ifdef FB_BOUNDS_CHECK_EN
    test_oob();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
